command_executor: RTL and testbench

//  Consumer end of the voice-recognition command interface. Takes the 4-bit
//  one-cycle command pulse produced by the DTW score/decision logic and turns
//  it into persistent actuator state.

---
 rtl/command_executor.sv | 142 ++++++++++++++
 tb/tb_command_executor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/command_executor.sv
// Turns one-cycle recognizer command pulses into persistent colour and motor state.
// It applies a holdoff lockout between accepted commands and times each turn.
//
// state      | meaning
// STOPPED    | both motors off
// FORWARD    | both motors on
// TURN_L     | right motor only, timed by turn_cnt, then return to resume state
// TURN_R     | left motor only, timed by turn_cnt, then return to resume state
module command_executor #(
  parameter int TURN_CYCLES    = 27000000,
  parameter int HOLDOFF_CYCLES = 2700000,
  parameter int CNT_W          = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] command,
  output logic       motor_left_fwd,
  output logic       motor_right_fwd,
  output logic [1:0] color,
  output logic       busy,
  output logic [3:0] last_command,
  output logic       cmd_ack,
  output logic       cmd_dropped,
  output logic       bad_cmd
);

  typedef enum logic [1:0] {ST_STOPPED, ST_FORWARD, ST_TURN_L, ST_TURN_R} state_t;

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d, resume_q, resume_d;
  logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d, hold_cnt_q, hold_cnt_d;
  logic [1:0]       color_q, color_d;
  logic [3:0]       last_q, last_d;
  logic             left_q, left_d, right_q, right_d, busy_q, busy_d;
  logic             ack_q, ack_d, drop_q, drop_d, bad_q, bad_d;
  logic             turning, is_color, is_motion;

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    turn_cnt_d = turn_cnt_q;
    hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - CNT_ONE : hold_cnt_q;
    color_d    = color_q;
    last_d     = last_q;
    ack_d      = 1'b0;
    drop_d     = 1'b0;
    bad_d      = 1'b0;
    turning    = (state_q == ST_TURN_L) || (state_q == ST_TURN_R);
    is_color   = (command[3:2] == 2'b01);
    is_motion  = (command[3:2] == 2'b10);

    if (turning) begin
      if (turn_cnt_q == '0) state_d = resume_q;
      else                  turn_cnt_d = turn_cnt_q - CNT_ONE;
    end

    if (command != 4'b0000 && !is_color && !is_motion) begin
      bad_d = 1'b1;
    end else if (is_color || is_motion) begin
      if (hold_cnt_q != '0) begin
        drop_d = 1'b1;
      end else begin
        ack_d      = 1'b1;
        last_d     = command;
        hold_cnt_d = HOLD_LOAD;
        if (is_color) begin
          color_d = command[1:0];
        end else begin
          case (command[1:0])
            2'b10: begin
              // GO mid-turn only retargets the return state; if the turn
              // expires on this edge the new target takes effect immediately.
              if (turning) begin
                resume_d = ST_FORWARD;
                if (turn_cnt_q == '0) state_d = ST_FORWARD;
              end else begin
                state_d = ST_FORWARD;
              end
            end
            2'b11: begin
              state_d    = ST_STOPPED;
              resume_d   = ST_STOPPED;
              turn_cnt_d = '0;
            end
            default: begin
              if (!turning) resume_d = state_q;
              state_d    = command[0] ? ST_TURN_R : ST_TURN_L;
              turn_cnt_d = TURN_LOAD;
            end
          endcase
        end
      end
    end

    left_d  = (state_d == ST_FORWARD) || (state_d == ST_TURN_R);
    right_d = (state_d == ST_FORWARD) || (state_d == ST_TURN_L);
    busy_d  = (state_d == ST_TURN_L) || (state_d == ST_TURN_R);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOPPED;
      resume_q   <= ST_STOPPED;
      turn_cnt_q <= '0;
      hold_cnt_q <= '0;
      color_q    <= 2'b00;
      last_q     <= 4'b0000;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      drop_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      turn_cnt_q <= turn_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      color_q    <= color_d;
      last_q     <= last_d;
      left_q     <= left_d;
      right_q    <= right_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      drop_q     <= drop_d;
      bad_q      <= bad_d;
    end
  end

  assign motor_left_fwd  = left_q;
  assign motor_right_fwd = right_q;
  assign color           = color_q;
  assign busy            = busy_q;
  assign last_command    = last_q;
  assign cmd_ack         = ack_q;
  assign cmd_dropped     = drop_q;
  assign bad_cmd         = bad_q;

endmodule

// File: tb/tb_command_executor.sv
// Directed bench for command_executor with TURN_CYCLES=4, HOLDOFF_CYCLES=2.
// Status byte = {left, right, busy, ack, dropped, bad, color[1:0]}.
module tb_command_executor;

  logic       clock;
  logic       reset;
  logic [3:0] command;
  logic       motor_left_fwd, motor_right_fwd, busy, cmd_ack, cmd_dropped, bad_cmd;
  logic [1:0] color;
  logic [3:0] last_command;

  int checks_cnt = 0;
  int errors_cnt = 0;

  command_executor #(.TURN_CYCLES(4), .HOLDOFF_CYCLES(2), .CNT_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .command(command),
    .motor_left_fwd(motor_left_fwd),
    .motor_right_fwd(motor_right_fwd),
    .color(color),
    .busy(busy),
    .last_command(last_command),
    .cmd_ack(cmd_ack),
    .cmd_dropped(cmd_dropped),
    .bad_cmd(bad_cmd)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] status();
    return {motor_left_fwd, motor_right_fwd, busy, cmd_ack, cmd_dropped, bad_cmd, color};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one command for one clock and land #1 after the sampling edge.
  task automatic cycle(input logic [3:0] cmd);
    command = cmd;
    @(posedge clock);
    #1;
  endtask

  initial begin
    command = 4'b0000;
    reset   = 1'b0;
    #3 reset = 1'b1;
    #4;
    check("reset_status", status(), 8'b0000_0000);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) cycle(4'b0000);
    check("idle_status", status(), 8'b0000_0000);
    check("idle_last", {4'b0, last_command}, 8'h00);

    cycle(4'b1010);
    check("go_status", status(), 8'b1101_0000);
    check("go_last", {4'b0, last_command}, 8'h0A);
    cycle(4'b0000);
    cycle(4'b0000);

    cycle(4'b1000);
    check("left_accept", status(), 8'b0111_0000);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000);
      check("left_hold", status(), 8'b0110_0000);
    end
    cycle(4'b0000);
    check("left_resume_fwd", status(), 8'b1100_0000);

    cycle(4'b1010);
    check("go_fwd", status(), 8'b1101_0000);
    cycle(4'b1011);
    check("drop_1", status(), 8'b1100_1000);
    cycle(4'b1011);
    check("drop_2", status(), 8'b1100_1000);
    cycle(4'b1011);
    check("stop_accept", status(), 8'b0001_0000);
    check("stop_last", {4'b0, last_command}, 8'h0B);
    cycle(4'b0000);
    cycle(4'b0000);

    cycle(4'b1001);
    check("right_accept", status(), 8'b1011_0000);
    cycle(4'b0000);
    check("right_n1", status(), 8'b1010_0000);
    cycle(4'b0000);
    check("right_n2", status(), 8'b1010_0000);
    cycle(4'b1010);
    check("go_in_turn", status(), 8'b1011_0000);
    cycle(4'b0000);
    check("resume_fwd", status(), 8'b1100_0000);
    cycle(4'b0000);

    cycle(4'b1101);
    check("bad_cmd", status(), 8'b1100_0100);
    check("bad_last", {4'b0, last_command}, 8'h0A);
    cycle(4'b0111);
    check("blue", status(), 8'b1101_0011);
    cycle(4'b0101);
    check("red_dropped", status(), 8'b1100_1011);
    cycle(4'b0000);

    cycle(4'b1000);
    check("left_from_fwd", status(), 8'b0111_0011);
    cycle(4'b0000);
    cycle(4'b0000);
    cycle(4'b1001);
    check("right_reload", status(), 8'b1011_0011);
    for (int i = 0; i < 3; i++) cycle(4'b0000);
    check("right_last_cycle", status(), 8'b1010_0011);
    cycle(4'b1000);
    check("cmd_beats_expiry", status(), 8'b0111_0011);
    cycle(4'b0000);
    cycle(4'b0000);
    cycle(4'b1011);
    check("stop_aborts_turn", status(), 8'b0001_0011);
    cycle(4'b0000);
    cycle(4'b0000);

    cycle(4'b1000);
    check("left_before_reset", status(), 8'b0111_0011);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_turn", status(), 8'b0000_0000);
    check("reset_last", {4'b0, last_command}, 8'h00);
    @(posedge clock);
    #1 reset = 1'b0;
    cycle(4'b0000);
    check("after_reset", status(), 8'b0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
